// File: rtl/io_dcd_pkg.sv
// Shared definitions for the IO decode area: sequencer state encoding and default timings.
package io_dcd_pkg;

   localparam int unsigned SeqStateW    = 2;
   localparam int unsigned PorCyclesDef = 568;

   typedef enum logic [SeqStateW-1:0] {
      StPor   = 2'd0,
      StRun   = 2'd1,
      StMcl   = 2'd2,
      StPfail = 2'd3
   } seq_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/io_sync_filter.sv
// Two-flop synchroniser followed by a debouncer: the output follows the synchronised input
// only after COUNT consecutive samples disagree with it.
module io_sync_filter #(
   parameter int unsigned COUNT   = 8,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic sysclk,
   input  logic sys_rst,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = $clog2(COUNT + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          filt_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
         filt_q  <= RST_VAL;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         // Any agreeing sample restarts the run of disagreeing ones.
         if (sync2_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(COUNT - 1)) begin
            filt_q <= sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign dout = filt_q;

endmodule

// File: rtl/io_mcl_sequencer.sv
// Power-on / master-clear sequencer driving DGA CLOSC, PWCL and POWSENSE.
// Define IO_MCL_EVTCNT_EN to add saturating MCL / power-fail event counters.
module io_mcl_sequencer
   import io_dcd_pkg::*;
#(
   parameter int unsigned POR_CYCLES = PorCyclesDef,
   parameter int unsigned MCL_CYCLES = 16,
   parameter int unsigned PF_FILTER  = 8,
   parameter int unsigned CNT_W      = 11
) (
   input  logic                 sysclk,
   input  logic                 sys_rst,
   input  logic                 OSCCL_n,
   input  logic                 SWMCL_n,
   input  logic                 OPCLCS,
   input  logic                 POWSENSE_n,
   output logic                 POR_ACTIVE,
   output logic                 CLOSC,
   output logic                 PWCL,
   output logic                 POWSENSE,
   output logic                 MCL_BUSY,
   output logic [SeqStateW-1:0] SEQ_STATE
`ifdef IO_MCL_EVTCNT_EN
   ,
   output logic [7:0]           MCL_EVTCNT,
   output logic [7:0]           PF_EVTCNT
`endif
);

   localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] MCL_LOAD = CNT_W'(MCL_CYCLES - 1);

   seq_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             por_active_q;
   logic             pwcl_q;
   logic             busy_q;
   logic             pf_raw;
   logic             pf_filt;
   logic             req;

   assign pf_raw = ~POWSENSE_n;
   assign req    = ~SWMCL_n | OPCLCS;

   io_sync_filter #(
      .COUNT   (PF_FILTER),
      .RST_VAL (1'b0)
   ) u_pf_filter (
      .sysclk  (sysclk),
      .sys_rst (sys_rst),
      .din     (pf_raw),
      .dout    (pf_filt)
   );

   // Output flops are updated together with the state so they always match it.
   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= StPor;
         cnt_q        <= POR_LOAD;
         por_active_q <= 1'b1;
         pwcl_q       <= 1'b1;
         busy_q       <= 1'b1;
      end else begin
         unique case (state_q)
            StPor: begin
               if (cnt_q == '0) begin
                  state_q      <= StRun;
                  por_active_q <= 1'b0;
                  pwcl_q       <= 1'b0;
                  busy_q       <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StRun: begin
               if (pf_filt) begin
                  state_q <= StPfail;
                  pwcl_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (req) begin
                  state_q <= StMcl;
                  cnt_q   <= MCL_LOAD;
                  pwcl_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StMcl: begin
               if (pf_filt) begin
                  state_q <= StPfail;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!req) begin
                  state_q <= StRun;
                  pwcl_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            StPfail: begin
               // Power return always takes a full restart.
               if (!pf_filt) begin
                  state_q      <= StPor;
                  cnt_q        <= POR_LOAD;
                  por_active_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= StPor;
               cnt_q        <= POR_LOAD;
               por_active_q <= 1'b1;
               pwcl_q       <= 1'b1;
               busy_q       <= 1'b1;
            end
         endcase
      end
   end

   assign POR_ACTIVE = por_active_q;
   assign CLOSC      = por_active_q | ~OSCCL_n;
   assign PWCL       = pwcl_q;
   assign POWSENSE   = pf_filt;
   assign MCL_BUSY   = busy_q;
   assign SEQ_STATE  = state_q;

`ifdef IO_MCL_EVTCNT_EN
   logic [7:0] mcl_evt_q;
   logic [7:0] pf_evt_q;

   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         mcl_evt_q <= '0;
         pf_evt_q  <= '0;
      end else begin
         if (state_q == StRun && !pf_filt && req) begin
            mcl_evt_q <= sat_inc8(mcl_evt_q);
         end
         if ((state_q == StRun || state_q == StMcl) && pf_filt) begin
            pf_evt_q <= sat_inc8(pf_evt_q);
         end
      end
   end

   assign MCL_EVTCNT = mcl_evt_q;
   assign PF_EVTCNT  = pf_evt_q;
`endif

endmodule

// File: tb/tb_io_mcl_sequencer.sv
// Self-checking bench for io_mcl_sequencer: directed vectors, hand sequences and a randomized
// run against a behavioural model. IO_MCL_EVTCNT_EN enables the event-counter checks.
module tb_io_mcl_sequencer;

   localparam int POR_N  = 568;
   localparam int MCL_N  = 16;
   localparam int FILT_N = 8;

   logic       sysclk     = 1'b0;
   logic       sys_rst    = 1'b1;
   logic       OSCCL_n    = 1'b1;
   logic       SWMCL_n    = 1'b1;
   logic       OPCLCS     = 1'b0;
   logic       POWSENSE_n = 1'b1;
   logic       POR_ACTIVE, CLOSC, PWCL, POWSENSE, MCL_BUSY;
   logic [1:0] SEQ_STATE;
`ifdef IO_MCL_EVTCNT_EN
   logic [7:0] MCL_EVTCNT, PF_EVTCNT;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   always #5 sysclk = ~sysclk;

   io_mcl_sequencer dut (
      .sysclk     (sysclk),
      .sys_rst    (sys_rst),
      .OSCCL_n    (OSCCL_n),
      .SWMCL_n    (SWMCL_n),
      .OPCLCS     (OPCLCS),
      .POWSENSE_n (POWSENSE_n),
      .POR_ACTIVE (POR_ACTIVE),
      .CLOSC      (CLOSC),
      .PWCL       (PWCL),
      .POWSENSE   (POWSENSE),
      .MCL_BUSY   (MCL_BUSY),
      .SEQ_STATE  (SEQ_STATE)
`ifdef IO_MCL_EVTCNT_EN
      ,
      .MCL_EVTCNT (MCL_EVTCNT),
      .PF_EVTCNT  (PF_EVTCNT)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   function automatic logic pick(input int s);
      case (s)
         0:       return POR_ACTIVE;
         1:       return PWCL;
         2:       return POWSENSE;
         default: return CLOSC;
      endcase
   endfunction

   // Consecutive samples (starting now) where the selected output equals val.
   task automatic run_len(input int s, input logic val, input int limit, output int n);
      n = 0;
      while (pick(s) === val && n < limit) begin
         n++;
         @(negedge sysclk);
      end
   endtask

   // Cycles until the selected output reaches val.
   task automatic latency(input int s, input logic val, input int limit, output int n);
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (pick(s) !== val && n < limit);
   endtask

   // ---------------- behavioural reference model ----------------
   int m_mode;      // 0 POR, 1 RUN, 2 MCL, 3 PFAIL
   int m_left;      // POR cycles still to be shown, including the current one
   int m_elapsed;   // cycles already spent in MCL
   bit m_pf;
   bit hist[$];     // raw power-fail level seen at the last 10 clock edges
   int m_mcl_evt, m_pf_evt;

   task automatic model_reset();
      m_mode = 0; m_left = POR_N; m_elapsed = 0; m_pf = 0;
      m_mcl_evt = 0; m_pf_evt = 0;
      hist = {};
      repeat (10) hist.push_back(1'b0);
   endtask

   task automatic model_step(input bit raw_fail, input bit req);
      bit flip;
      case (m_mode)
         0: if (m_left == 1) m_mode = 1; else m_left--;
         1: begin
            if (m_pf) begin
               m_mode = 3; m_pf_evt = (m_pf_evt < 255) ? m_pf_evt + 1 : 255;
            end else if (req) begin
               m_mode = 2; m_elapsed = 1; m_mcl_evt = (m_mcl_evt < 255) ? m_mcl_evt + 1 : 255;
            end
         end
         2: begin
            if (m_pf) begin
               m_mode = 3; m_pf_evt = (m_pf_evt < 255) ? m_pf_evt + 1 : 255;
            end else if (m_elapsed >= MCL_N && !req) m_mode = 1;
            else m_elapsed++;
         end
         default: if (!m_pf) begin m_mode = 0; m_left = POR_N; end
      endcase
      // Filter sees the raw level two edges late; it flips after FILT_N disagreeing samples.
      hist.push_back(raw_fail);
      void'(hist.pop_front());
      flip = 1'b1;
      for (int i = 0; i < FILT_N; i++) if (hist[i] == m_pf) flip = 1'b0;
      if (flip) m_pf = !m_pf;
   endtask

   // ---------------- directed vectors (applied from RUN) ----------------
   typedef struct {
      logic osccl_n, swmcl_n, opclcs, powsense_n;
      int   hold;
      logic closc, pwcl, busy, ps;
      logic [1:0] state;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int n, np, nc, burst;

      vecs[0] = '{1, 1, 0, 1,  1, 0, 0, 0, 0, 2'd1};
      vecs[1] = '{0, 1, 0, 1,  1, 1, 0, 0, 0, 2'd1};
      vecs[2] = '{1, 0, 0, 1,  1, 0, 1, 1, 0, 2'd2};
      vecs[3] = '{1, 1, 0, 1, 15, 0, 1, 1, 0, 2'd2};
      vecs[4] = '{1, 1, 0, 1,  1, 0, 0, 0, 0, 2'd1};
      vecs[5] = '{1, 1, 1, 1,  1, 0, 1, 1, 0, 2'd2};
      vecs[6] = '{0, 1, 1, 1, 20, 1, 1, 1, 0, 2'd2};
      vecs[7] = '{1, 1, 0, 1,  1, 0, 0, 0, 0, 2'd1};
      vecs[8] = '{1, 1, 0, 0,  5, 0, 0, 0, 0, 2'd1};
      vecs[9] = '{1, 1, 0, 1, 10, 0, 0, 0, 0, 2'd1};

      // 1: reset values, then exact POR length
      @(negedge sysclk);
      check("rst_por_active", POR_ACTIVE, 1);
      check("rst_closc", CLOSC, 1);
      check("rst_pwcl", PWCL, 1);
      check("rst_busy", MCL_BUSY, 1);
      check("rst_state", SEQ_STATE, 0);
      check("rst_powsense", POWSENSE, 0);
      sys_rst = 1'b0;
      n = 0; np = 0; nc = 0;
      while (POR_ACTIVE === 1'b1 && n < 2000) begin
         if (PWCL) np++;
         if (CLOSC) nc++;
         n++;
         @(negedge sysclk);
      end
      check("por_len", n, POR_N);
      check("por_pwcl_len", np, POR_N);
      check("por_closc_len", nc, POR_N);
      check("por_end_state", SEQ_STATE, 1);
      check("por_end_pwcl", PWCL, 0);
      check("por_end_closc", CLOSC, 0);

      for (int i = 0; i < 10; i++) begin
         OSCCL_n = vecs[i].osccl_n; SWMCL_n = vecs[i].swmcl_n;
         OPCLCS = vecs[i].opclcs; POWSENSE_n = vecs[i].powsense_n;
         cyc(vecs[i].hold);
         check($sformatf("vec%0d_closc", i), CLOSC, vecs[i].closc);
         check($sformatf("vec%0d_pwcl", i), PWCL, vecs[i].pwcl);
         check($sformatf("vec%0d_busy", i), MCL_BUSY, vecs[i].busy);
         check($sformatf("vec%0d_powsense", i), POWSENSE, vecs[i].ps);
         check($sformatf("vec%0d_state", i), SEQ_STATE, vecs[i].state);
      end

      // 2: one-cycle SWMCL_n pulse is stretched to MCL_N cycles
      cyc(2);
      SWMCL_n = 1'b0;
      cyc(1);
      SWMCL_n = 1'b1;
      run_len(1, 1'b1, 200, n);
      check("swmcl_pwcl_len", n, MCL_N);
      check("swmcl_back_run", SEQ_STATE, 1);
      // long OPCLCS: PWCL covers the whole request and drops one edge after release
      cyc(2);
      OPCLCS = 1'b1;
      np = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sysclk);
         if (PWCL) np++;
      end
      OPCLCS = 1'b0;
      run_len(1, 1'b1, 200, n);
      check("opclcs_pwcl_len", np + n - 1, 40);
      check("opclcs_back_run", SEQ_STATE, 1);

      // 3: short POWSENSE_n dip is filtered out, long one reaches PFAIL
      cyc(2);
      POWSENSE_n = 1'b0;
      np = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge sysclk);
         if (i == 4) POWSENSE_n = 1'b1;
         if (POWSENSE) np++;
      end
      check("glitch_powsense", np, 0);
      check("glitch_state", SEQ_STATE, 1);
      POWSENSE_n = 1'b0;
      latency(2, 1'b1, 100, n);
      check("pf_latency", n, FILT_N + 2);
      cyc(1);
      check("pf_state", SEQ_STATE, 3);
      check("pf_pwcl", PWCL, 1);
      cyc(9);
      // 4: power returns, filtered release, then full restart
      POWSENSE_n = 1'b1;
      latency(2, 1'b0, 100, n);
      check("pf_release_latency", n, FILT_N + 2);
      check("pf_hold_state", SEQ_STATE, 3);
      cyc(1);
      check("restart_state", SEQ_STATE, 0);
      run_len(0, 1'b1, 2000, n);
      check("restart_por_len", n, POR_N);
      check("restart_run", SEQ_STATE, 1);

      // 5: asynchronous reset in the middle of MCL
      SWMCL_n = 1'b0;
      cyc(1);
      SWMCL_n = 1'b1;
      cyc(8);
      check("mid_mcl_state", SEQ_STATE, 2);
      #1 sys_rst = 1'b1;
      #1;
      check("async_rst_state", SEQ_STATE, 0);
      check("async_rst_pwcl", PWCL, 1);
      check("async_rst_por", POR_ACTIVE, 1);
      @(negedge sysclk);
      sys_rst = 1'b0;
      run_len(0, 1'b1, 2000, n);
      check("rst_mcl_por_len", n, POR_N);

      // randomized run against the model
      @(negedge sysclk);
      sys_rst = 1'b1;
      @(negedge sysclk);
      sys_rst = 1'b0;
      model_reset();
      burst = 0;
      for (int i = 0; i < 8000; i++) begin
         check("rnd_state", SEQ_STATE, m_mode);
         check("rnd_por", POR_ACTIVE, m_mode == 0);
         check("rnd_pwcl", PWCL, m_mode != 1);
         check("rnd_busy", MCL_BUSY, m_mode != 1);
         check("rnd_powsense", POWSENSE, m_pf);
         check("rnd_closc", CLOSC, (m_mode == 0) || !OSCCL_n);
`ifdef IO_MCL_EVTCNT_EN
         check("rnd_mcl_evt", MCL_EVTCNT, m_mcl_evt);
         check("rnd_pf_evt", PF_EVTCNT, m_pf_evt);
`endif
         if ($urandom_range(0, 99) == 0) POWSENSE_n = !POWSENSE_n;
         SWMCL_n = ($urandom_range(0, 29) != 0);
         OSCCL_n = ($urandom_range(0, 7) != 0);
         if (burst > 0) begin
            burst--;
            OPCLCS = 1'b1;
         end else begin
            OPCLCS = 1'b0;
            if ($urandom_range(0, 99) == 0) burst = $urandom_range(1, 40);
         end
         model_step(!POWSENSE_n, !SWMCL_n || OPCLCS);
         @(negedge sysclk);
      end

`ifdef IO_MCL_EVTCNT_EN
      // 6: MCL event counter saturates; power-fail counter untouched
      OSCCL_n = 1'b1; SWMCL_n = 1'b1; OPCLCS = 1'b0; POWSENSE_n = 1'b1;
      sys_rst = 1'b1;
      @(negedge sysclk);
      sys_rst = 1'b0;
      check("evt_rst_mcl", MCL_EVTCNT, 0);
      check("evt_rst_pf", PF_EVTCNT, 0);
      cyc(POR_N + 2);
      for (int i = 0; i < 300; i++) begin
         SWMCL_n = 1'b0;
         cyc(1);
         SWMCL_n = 1'b1;
         cyc(MCL_N + 1);
      end
      check("evt_mcl_sat", MCL_EVTCNT, 8'hFF);
      check("evt_pf_unchanged", PF_EVTCNT, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
